// File: rtl/spi_ram_responder.sv
// spi_ram_responder
//   SPI mode-0 target that behaves like a small byte-addressed serial SRAM.
//   It accepts READ (0x03) and WRITE (0x02), each followed by an ADDR_BITS address
//   sent MSB first. Data then streams in sequential mode: the address
//   auto-increments and wraps modulo MEM_BYTES until select is released.
//   All SPI pins are oversampled in the clk domain. The backing store also has a
//   host-side port for preload and inspection.
// Ports
//   clk, rstn      system clock, async active-low reset
//   spi_select     chip select, active low (async)
//   spi_clk        SCK, idle low (async)
//   spi_mosi       initiator -> target data, sampled on SCK rise
//   spi_miso       target -> initiator data, updated after SCK fall, 0 when not reading
//   host_we        host write strobe for mem[host_addr] <= host_wdata
//   host_addr      host byte address
//   host_wdata     host write data
//   host_rdata     registered mem[host_addr]
//   active         synchronised select is asserted
//   bad_cmd        single-cycle pulse when the command byte is unknown
module spi_ram_responder #(
  parameter int ADDR_BITS = 16,
  parameter int MEM_BYTES = 64
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         spi_select,
  input  logic                         spi_clk,
  input  logic                         spi_mosi,
  output logic                         spi_miso,
  input  logic                         host_we,
  input  logic [$clog2(MEM_BYTES)-1:0] host_addr,
  input  logic [7:0]                   host_wdata,
  output logic [7:0]                   host_rdata,
  output logic                         active,
  output logic                         bad_cmd
);
  localparam int IDX_W = $clog2(MEM_BYTES);
  localparam int CNT_W = $clog2(ADDR_BITS > 8 ? ADDR_BITS : 8);
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_IGNORE} state_t;

  state_t state, state_nxt;

  // Select passes through three flops so that active, and the FSM reacting to
  // select, both line up with the 3-clk latency of the SCK edge detector.
  logic sel_meta, sel_sync, sel_n;
  logic sck_meta, sck_sync, sck_prev;
  logic mosi_meta, mosi_sync;
  logic sck_rise, sck_fall;

  logic [CNT_W-1:0] bit_cnt;
  logic [6:0]       rx_shift;
  logic [7:0]       rx_next;
  logic [7:0]       tx_shift;
  logic [IDX_W-1:0] addr, addr_next;
  logic             is_read;
  logic             miso_q, bad_cmd_q, bad_cmd_nxt;
  logic [7:0]       host_rdata_q;
  logic [7:0]       mem [MEM_BYTES];

  logic last_byte_bit, last_addr_bit;

  assign sck_rise      = sck_sync & ~sck_prev;
  assign sck_fall      = ~sck_sync & sck_prev;
  assign rx_next       = {rx_shift, mosi_sync};
  // Only the low IDX_W address bits are kept; upper bits shift out and alias.
  assign addr_next     = {addr[IDX_W-2:0], mosi_sync};
  assign last_byte_bit = (bit_cnt == CNT_W'(7));
  assign last_addr_bit = (bit_cnt == CNT_W'(ADDR_BITS - 1));

  assign spi_miso   = miso_q;
  assign bad_cmd    = bad_cmd_q;
  assign host_rdata = host_rdata_q;
  assign active     = ~sel_n;

  // synchronisers and edge detect
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_meta  <= 1'b1;
      sel_sync  <= 1'b1;
      sel_n     <= 1'b1;
      sck_meta  <= 1'b0;
      sck_sync  <= 1'b0;
      sck_prev  <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      sel_meta  <= spi_select;
      sel_sync  <= sel_meta;
      sel_n     <= sel_sync;
      sck_meta  <= spi_clk;
      sck_sync  <= sck_meta;
      sck_prev  <= sck_sync;
      mosi_meta <= spi_mosi;
      mosi_sync <= mosi_meta;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt   = state;
    bad_cmd_nxt = 1'b0;
    if (sel_n) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_CMD;
        S_CMD: begin
          if (sck_rise && last_byte_bit) begin
            if (rx_next == CMD_READ || rx_next == CMD_WRITE) begin
              state_nxt = S_ADDR;
            end else begin
              state_nxt   = S_IGNORE;
              bad_cmd_nxt = 1'b1;
            end
          end
        end
        S_ADDR: if (sck_rise && last_addr_bit) state_nxt = S_DATA;
        default: ;
      endcase
    end
  end

  // datapath and backing store
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt      <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      addr         <= '0;
      is_read      <= 1'b0;
      miso_q       <= 1'b0;
      bad_cmd_q    <= 1'b0;
      host_rdata_q <= '0;
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
    end else begin
      bad_cmd_q    <= bad_cmd_nxt;
      host_rdata_q <= mem[host_addr];
      // Host write comes first so a same-cycle SPI write to the same byte overrides it.
      if (host_we) mem[host_addr] <= host_wdata;

      if (sel_n || state == S_IDLE) begin
        // Deselect drops any partial byte.
        bit_cnt <= '0;
        miso_q  <= 1'b0;
      end else begin
        if (!(state == S_DATA && is_read)) miso_q <= 1'b0;
        if (sck_rise) begin
          case (state)
            S_CMD: begin
              rx_shift <= rx_next[6:0];
              bit_cnt  <= last_byte_bit ? '0 : bit_cnt + CNT_W'(1);
              if (last_byte_bit) is_read <= (rx_next == CMD_READ);
            end
            S_ADDR: begin
              addr    <= addr_next;
              bit_cnt <= last_addr_bit ? '0 : bit_cnt + CNT_W'(1);
              // Prefetch so the first data bit is ready for the next SCK fall.
              if (last_addr_bit && is_read) tx_shift <= mem[addr_next];
            end
            S_DATA: begin
              rx_shift <= rx_next[6:0];
              if (last_byte_bit) begin
                bit_cnt <= '0;
                addr    <= addr + IDX_W'(1);
                if (is_read) tx_shift <= mem[addr + IDX_W'(1)];
                else         mem[addr] <= rx_next;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
            default: ;
          endcase
        end else if (sck_fall && state == S_DATA && is_read) begin
          miso_q   <= tx_shift[7];
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

endmodule
